// File: rtl/tx_4b.sv
// Transmit stage of the 4-bit SPI-style link: takes result words over valid/ready
// and returns them to the host one nibble per spi_clk, most-significant nibble first.
module tx_4b #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 spi_clk,
  input  logic                 spi_r,
  input  logic [4*NIBBLES-1:0] res_data,
  input  logic                 res_valid,
  output logic                 res_ready,
  output logic [3:0]           miso,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_LOADED = 2'd1,
    ST_SHIFT  = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_hold_valid;
  logic [W-1:0]    r_hold;
  logic [W-1:0]    r_frame;
  logic [CW-1:0]   r_cnt;
  logic            r_spi_clk_prev;
  logic            r_tx_done;

  logic            w_fall;
  logic            w_accept;
  logic [3:0]      w_nib;

  assign w_fall    = r_spi_clk_prev & ~spi_clk;
  assign w_accept  = res_valid & ~r_hold_valid;
  assign res_ready = ~r_hold_valid;
  assign tx_busy   = (r_state != ST_EMPTY);
  assign tx_done   = r_tx_done;

  // Index mux rather than a shifter, so an aborted read can restart from nibble 0.
  always_comb begin
    w_nib = 4'h0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (r_cnt == CW'(i)) w_nib = r_frame[W-1-4*i -: 4];
    end
  end

  assign miso = (r_state == ST_EMPTY) ? 4'h0 : w_nib;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_EMPTY;
      r_hold_valid   <= 1'b0;
      r_hold         <= '0;
      r_frame        <= '0;
      r_cnt          <= '0;
      r_spi_clk_prev <= 1'b0;
      r_tx_done      <= 1'b0;
    end else begin
      r_spi_clk_prev <= spi_clk;
      r_tx_done      <= 1'b0;

      // Accept and promote are mutually exclusive: one needs the holding register empty, the other full.
      if (w_accept) begin
        r_hold       <= res_data;
        r_hold_valid <= 1'b1;
      end

      case (r_state)
        ST_EMPTY: begin
          if (r_hold_valid) begin
            r_frame      <= r_hold;
            r_hold_valid <= 1'b0;
            r_cnt        <= '0;
            r_state      <= ST_LOADED;
          end
        end
        ST_LOADED: begin
          if (spi_r) r_state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (!spi_r) begin
            r_state <= ST_LOADED;
            r_cnt   <= '0;
          end else if (w_fall) begin
            if (r_cnt == LAST) begin
              r_state   <= ST_EMPTY;
              r_cnt     <= '0;
              r_tx_done <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_4b.sv
// Bench for tx_4b: fixed frame table, hand-written corner sequences and a randomized
// run checked against a word-queue model of what the host should read back.
module tb_tx_4b;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        spi_clk = 1'b0;
  logic        spi_r = 1'b0;
  logic [15:0] res_data = '0;
  logic        res_valid = 1'b0;
  logic        res_ready;
  logic [3:0]  miso;
  logic        tx_busy;
  logic        tx_done;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  tx_4b #(.NIBBLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .spi_clk   (spi_clk),
    .spi_r     (spi_r),
    .res_data  (res_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .miso      (miso),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (tx_done === 1'b1) done_cnt++;

  typedef struct {
    logic [15:0]      data;
    logic [3:0][3:0]  nibs;   // nibs[3] is read first
  } vec_t;

  vec_t vt[5];
  logic [15:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_busy();
    int n = 0;
    while (tx_busy !== 1'b1 && n < 50) begin
      step(1);
      n++;
    end
    chk("wait_busy", 32'(tx_busy), 32'd1);
  endtask

  task automatic send(input logic [15:0] w);
    int n = 0;
    while (res_ready !== 1'b1 && n < 50) begin
      step(1);
      n++;
    end
    chk("send_ready", 32'(res_ready), 32'd1);
    res_data  = w;
    res_valid = 1'b1;
    step(1);
    res_valid = 1'b0;
  endtask

  task automatic pulse(input int hi, input int lo, output logic [3:0] nib);
    nib = miso;
    spi_clk = 1'b1;
    step(hi);
    spi_clk = 1'b0;
    step(lo);
  endtask

  task automatic read_frame(input string nm, input logic [15:0] e, input int hi, input int lo);
    int d0;
    logic [3:0] nb;
    wait_busy();
    spi_r = 1'b1;
    step(1);
    d0 = done_cnt;
    for (int j = 0; j < 4; j++) begin
      pulse(hi, lo, nb);
      chk(nm, 32'(nb), 32'(e[15-4*j -: 4]));
    end
    spi_r = 1'b0;
    step(1);
    chk({nm, "_done"}, 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    logic [3:0] nb;
    int d0;

    vt[0] = '{16'hA5C3, {4'hA, 4'h5, 4'hC, 4'h3}};
    vt[1] = '{16'h0000, {4'h0, 4'h0, 4'h0, 4'h0}};
    vt[2] = '{16'hFFFF, {4'hF, 4'hF, 4'hF, 4'hF}};
    vt[3] = '{16'h8001, {4'h8, 4'h0, 4'h0, 4'h1}};
    vt[4] = '{16'h1E2D, {4'h1, 4'hE, 4'h2, 4'hD}};

    // 1: reset with offered data and a toggling spi_clk
    res_data = 16'h5555;
    res_valid = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      spi_clk = ~spi_clk;
      step(1);
      chk("rst_ready", 32'(res_ready), 32'd1);
      chk("rst_miso",  32'(miso),      32'd0);
      chk("rst_busy",  32'(tx_busy),   32'd0);
      chk("rst_done",  32'(tx_done),   32'd0);
    end
    spi_clk = 1'b0;
    res_valid = 1'b0;
    step(1);
    rst = 1'b0;
    step(3);
    chk("post_rst_ready", 32'(res_ready), 32'd1);
    chk("post_rst_busy",  32'(tx_busy),   32'd0);

    // 2: single frame with exact tx_done timing
    send(16'hA5C3);
    step(1);
    chk("lat_busy", 32'(tx_busy), 32'd1);
    chk("lat_miso", 32'(miso), 32'hA);
    spi_r = 1'b1;
    step(1);
    d0 = done_cnt;
    for (int j = 0; j < 3; j++) begin
      pulse(4, 4, nb);
      chk("single_nib", 32'(nb), 32'(vt[0].nibs[3-j]));
    end
    nb = miso;
    chk("single_nib3", 32'(nb), 32'h3);
    spi_clk = 1'b1;
    step(4);
    spi_clk = 1'b0;
    chk("done_before", 32'(tx_done), 32'd0);
    step(1);
    chk("done_pulse", 32'(tx_done), 32'd1);
    step(1);
    chk("done_after", 32'(tx_done), 32'd0);
    chk("end_busy", 32'(tx_busy), 32'd0);
    chk("end_miso", 32'(miso), 32'd0);
    chk("single_done_cnt", 32'(done_cnt - d0), 32'd1);
    spi_r = 1'b0;
    step(2);

    // table of frames
    for (int i = 0; i < 5; i++) begin
      send(vt[i].data);
      read_frame("table_nib", vt[i].nibs, 3, 3);
      chk("table_idle_busy", 32'(tx_busy), 32'd0);
      chk("table_idle_miso", 32'(miso), 32'd0);
    end

    // 3: back-to-back with backpressure
    send(16'h1234);
    wait_busy();
    spi_r = 1'b1;
    step(1);
    d0 = done_cnt;
    pulse(4, 4, nb);
    chk("b2b_f1", 32'(nb), 32'h1);
    send(16'hBEEF);
    res_data = 16'h0F0F;
    res_valid = 1'b1;
    step(1);
    chk("b2b_bp", 32'(res_ready), 32'd0);
    for (int j = 1; j < 4; j++) begin
      pulse(4, 4, nb);
      chk("b2b_f1", 32'(nb), 32'(j + 1));
      if (j < 3) chk("b2b_bp", 32'(res_ready), 32'd0);
    end
    res_valid = 1'b0;
    chk("b2b_f1_done", 32'(done_cnt - d0), 32'd1);
    chk("b2b_held", 32'(res_ready), 32'd0);
    spi_r = 1'b0;
    step(1);
    read_frame("b2b_f2", 16'hBEEF, 4, 4);
    read_frame("b2b_f3", 16'h0F0F, 4, 4);
    step(3);
    chk("b2b_empty", 32'(tx_busy), 32'd0);

    // 4: abort after two falls, then restart
    send(16'hA5C3);
    wait_busy();
    spi_r = 1'b1;
    step(1);
    pulse(4, 4, nb);
    chk("abort_n0", 32'(nb), 32'hA);
    pulse(4, 4, nb);
    chk("abort_n1", 32'(nb), 32'h5);
    chk("abort_pre", 32'(miso), 32'hC);
    d0 = done_cnt;
    spi_r = 1'b0;
    step(1);
    chk("abort_miso", 32'(miso), 32'hA);
    chk("abort_busy", 32'(tx_busy), 32'd1);
    chk("abort_nodone", 32'(done_cnt - d0), 32'd0);

    // 5: edges ignored in LOADED with spi_r low
    for (int i = 0; i < 3; i++) begin
      pulse(3, 3, nb);
      chk("loaded_ign", 32'(miso), 32'hA);
    end
    read_frame("restart", 16'hA5C3, 4, 4);
    d0 = done_cnt;
    spi_r = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pulse(3, 3, nb);
      chk("empty_miso", 32'(miso), 32'd0);
    end
    spi_r = 1'b0;
    chk("empty_nodone", 32'(done_cnt - d0), 32'd0);
    chk("empty_busy", 32'(tx_busy), 32'd0);

    // 6: mid-frame reset with a word held
    send(16'h1234);
    wait_busy();
    spi_r = 1'b1;
    step(1);
    pulse(4, 4, nb);
    pulse(4, 4, nb);
    send(16'hBEEF);
    chk("mid_held", 32'(res_ready), 32'd0);
    chk("mid_miso", 32'(miso), 32'h3);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(res_ready), 32'd1);
    chk("mid_rst_miso",  32'(miso),      32'd0);
    chk("mid_rst_busy",  32'(tx_busy),   32'd0);
    step(2);
    rst = 1'b0;
    d0 = done_cnt;
    for (int i = 0; i < 5; i++) begin
      pulse(3, 3, nb);
      chk("mid_after_miso", 32'(nb), 32'd0);
    end
    spi_r = 1'b0;
    step(1);
    chk("mid_after_nodone", 32'(done_cnt - d0), 32'd0);
    chk("mid_after_busy", 32'(tx_busy), 32'd0);

    // randomized frames with optional early delivery and aborts
    begin
      logic [15:0] words[20];
      int nxt;
      for (int i = 0; i < 20; i++) words[i] = 16'($urandom);
      exp_q = {};
      send(words[0]);
      exp_q.push_back(words[0]);
      nxt = 1;
      for (int i = 0; i < 20; i++) begin
        logic [15:0] w;
        int hi, lo, k;
        hi = $urandom_range(2, 5);
        lo = $urandom_range(2, 5);
        wait_busy();
        if (nxt < 20 && $urandom_range(0, 1) == 1) begin
          send(words[nxt]);
          exp_q.push_back(words[nxt]);
          nxt++;
        end
        w = exp_q.pop_front();
        k = $urandom_range(0, 3);
        if (k > 0) begin
          spi_r = 1'b1;
          step(1);
          for (int j = 0; j < k; j++) begin
            pulse(hi, lo, nb);
            chk("rnd_abort_nib", 32'(nb), 32'((w >> (4 * (3 - j))) & 16'hF));
          end
          spi_r = 1'b0;
          step(1);
          chk("rnd_abort_miso", 32'(miso), 32'(w >> 12));
        end
        read_frame("rnd_nib", w, hi, lo);
        if (nxt == i + 1 && nxt < 20) begin
          send(words[nxt]);
          exp_q.push_back(words[nxt]);
          nxt++;
        end
      end
      step(3);
      chk("rnd_drained", 32'(tx_busy), 32'd0);
      chk("rnd_queue", 32'(exp_q.size()), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tx_4b.md
Name: tx_4b

Overview:
- Transmit stage of the 4-bit SPI-style link; the counterpart of the RX stage.
- Accepts a result word from the ALU/output stage over a valid/ready handshake.
- Returns the word to the host one nibble per SPI clock on a 4-bit MISO bus, most-significant nibble first.
- A one-entry holding register lets the ALU deliver the next result while the current frame is being shifted out.

Parameters:
- NIBBLES, 4, nibbles per result frame; result width is 4*NIBBLES bits; must be >= 2.

Ports:
- clk  input  1  system clock; all logic is synchronous to its rising edge.
- rst  input  1  reset, asynchronous and active-high; clears all state.
- spi_clk  input  1  SPI clock from host, sampled in the clk domain (no synchronizer).
- spi_r  input  1  SPI read enable; high for the duration of a read frame.
- res_data  input  4*NIBBLES  result word from the ALU.
- res_valid  input  1  res_data is valid.
- res_ready  output  1  holding register empty; a transfer occurs when res_valid && res_ready.
- miso  output  4  current output nibble.
- tx_busy  output  1  a frame is loaded or being shifted.
- tx_done  output  1  one-cycle pulse when the last nibble of a frame completes.

Behaviour:
- Reset: state=EMPTY, hold_valid=0, cnt=0, frame=0, hold=0, spi_clk_prev=0. Outputs: miso=0, tx_busy=0, tx_done=0, res_ready=1.
- Edge detect: spi_clk_prev is registered each clk. fall = spi_clk_prev & ~spi_clk.
- res_ready = ~hold_valid (combinational).
- Accept: on res_valid && res_ready, hold <= res_data and hold_valid <= 1. No accept can occur while hold_valid=1.
- Promote: in EMPTY with hold_valid=1, on the next clk: frame <= hold, hold_valid <= 0, cnt <= 0, state <= LOADED. res_ready rises the following cycle.
- Accept-to-LOADED latency is 2 clk.
- State machine (states EMPTY / LOADED / SHIFT):
  - EMPTY: miso=0. spi_clk edges and spi_r are ignored.
  - LOADED: miso = frame nibble cnt, where nibble 0 = bits [4*NIBBLES-1 -: 4]. If spi_r=1, go to SHIFT. A fall in that same cycle is ignored.
  - SHIFT, spi_r=1 and fall, cnt < NIBBLES-1: cnt <= cnt+1.
  - SHIFT, spi_r=1 and fall, cnt == NIBBLES-1: state <= EMPTY, cnt <= 0, tx_done=1 for exactly one cycle, miso=0 from the next cycle.
  - SHIFT, spi_r=0: abort. State <= LOADED and cnt <= 0; frame is retained, so the next read restarts from nibble 0.
- Protocol timing: the host samples miso on spi_clk rising edges. miso changes only 1 clk after a detected falling edge, so each nibble is stable across the following high phase.
- Rising edges never advance cnt.
- miso is driven from a frame index mux, not a destructive shifter, so an abort loses no data.
- tx_busy = (state != EMPTY).
- Simultaneous events:
  - Accept during SHIFT is allowed; the held word waits until EMPTY.
  - The frame-completion cycle and promotion never coincide: promotion happens in the cycle after completion.
- Reset asserted mid-frame: frame and hold contents are discarded, and all outputs return to their reset values immediately (asynchronously).

Test Plan:
1. Reset: assert rst with res_valid=1 and spi_clk toggling -> res_ready=1, miso=0, tx_busy=0, tx_done=0 throughout; after release, no accept until a cycle with rst=0.
2. Single frame: res_data=16'hA5C3 with res_valid for 1 cycle; spi_r=1; 4 spi_clk pulses (4 clk high / 4 clk low) -> miso sampled at spi_clk rises = A,5,C,3; tx_done pulses once, 1 clk after the 4th fall; then tx_busy=0, miso=0.
3. Back-to-back with backpressure: offer 16'h1234, then 16'hBEEF during the first frame (accepted), then 16'h0F0F -> res_ready=0 until BEEF is promoted; host reads 1,2,3,4 / B,E,E,F / 0,F,0,F over three frames; no word lost or duplicated.
4. Abort/restart: frame 16'hA5C3; drop spi_r after 2 falls -> miso returns to A in LOADED; re-raise spi_r, 4 pulses -> A,5,C,3 and a single tx_done.
5. Ignored edges: spi_clk toggling with spi_r=0 in LOADED -> cnt stays 0, miso=A. Toggling in EMPTY -> miso=0, tx_done never asserts.
6. Mid-frame reset: assert rst after 2 nibbles with a word also held -> immediate reset outputs; after release, spi_r pulses produce miso=0 and no tx_done.
